regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_wb_pkg.sv | 14 +
 rtl/regfile_writeback_if.sv | 47 ++++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/regfile_writeback.sv | 109 ++++++++++
 tb/tb_regfile_writeback.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths, defaults and entry type for the writeback queue
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN_DEF   = 32;
  localparam int DEPTH_DEF  = 4;

  // Default-width queue entry; the top builds the same shape at its own XLEN.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - result sources, register-file write port and hazard query bundle
interface regfile_writeback_if
  import regfile_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]       ld_data;

  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       data_in;
  logic                  RegWrite;

  logic [REG_ADDR_W-1:0] chk_rs1;
  logic [REG_ADDR_W-1:0] chk_rs2;
  logic                  pend_rs1;
  logic                  pend_rs2;

  // Producer / decode side of the bundle.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output chk_rs1, chk_rs2,
    input  alu_ready, ld_ready,
    input  rd, data_in, RegWrite,
    input  pend_rs1, pend_rs2
  );

  // Writeback block side of the bundle.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  chk_rs1, chk_rs2,
    output alu_ready, ld_ready,
    output rd, data_in, RegWrite,
    output pend_rs1, pend_rs2
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular writeback queue exposing every slot for hazard lookup
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output entry_t [DEPTH-1:0]     entries,
  output logic   [DEPTH-1:0]     valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t [DEPTH-1:0] mem;
  logic   [PTR_W-1:0] wr_ptr;
  logic   [PTR_W-1:0] rd_ptr;
  logic   [CNT_W-1:0] count;
  logic               do_push;
  logic               do_pop;
  logic   [PTR_W-1:0] offset;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Slot storage; contents are qualified by valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count holds on push+pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - rd_ptr;
      valid[i] = (CNT_W'(offset) < count);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - arbitrates ALU/load results into a queue and drives the register-file write port
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_writeback_if.slave   bus
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  entry_t                  push_entry;
  entry_t                  head;
  entry_t [DEPTH-1:0]      entries;
  logic   [DEPTH-1:0]      valid;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    ld_fire;
  logic                    alu_fire;
  logic                    ld_ready;
  logic                    alu_ready;
  logic                    we_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [XLEN-1:0]         data_q;
  logic                    pend1;
  logic                    pend2;

  // Ready depends only on occupancy, so a pop never frees a slot in the same cycle.
  assign ld_ready  = rst_n && !full;
  assign alu_ready = rst_n && !full && !bus.ld_valid;
  assign ld_fire   = bus.ld_valid && ld_ready;
  assign alu_fire  = bus.alu_valid && alu_ready;
  assign pop       = !empty;

  // Load wins; writes to x0 complete the handshake but never reach the queue.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (ld_fire) begin
      push_entry = '{rd: bus.ld_rd, data: bus.ld_data};
      push       = (bus.ld_rd != '0);
    end else if (alu_fire) begin
      push_entry = '{rd: bus.alu_rd, data: bus.alu_data};
      push       = (bus.alu_rd != '0);
    end
  end

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (push_entry),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .entries (entries),
    .valid   (valid)
  );

  // Output stage: present the head for one cycle; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        rd_q   <= head.rd;
        data_q <= head.data;
      end
    end
  end

  // Hazard compare against queued slots and the write currently being presented.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i].rd == bus.chk_rs1) pend1 = 1'b1;
      if (valid[i] && entries[i].rd == bus.chk_rs2) pend2 = 1'b1;
    end
    if (we_q && rd_q == bus.chk_rs1) pend1 = 1'b1;
    if (we_q && rd_q == bus.chk_rs2) pend2 = 1'b1;
    if (bus.chk_rs1 == '0) pend1 = 1'b0;
    if (bus.chk_rs2 == '0) pend2 = 1'b0;
  end

  assign bus.ld_ready  = ld_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.RegWrite  = we_q;
  assign bus.rd        = rd_q;
  assign bus.data_in   = data_q;
  assign bus.pend_rs1  = pend1;
  assign bus.pend_rs2  = pend2;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - randomized and directed bench for regfile_writeback
module tb_regfile_writeback;
  import regfile_wb_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(XLEN)) bus();

  regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t       dut_log[$];
  wr_t       m_log[$];
  wb_entry_t mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;
  wb_entry_t   m_acc;
  logic        m_have;
  logic        m_room;
  wb_entry_t   m_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
  endtask

  // A register is pending if any accepted, not yet finished write targets it.
  function automatic logic m_pend(input logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    if (m_we && m_rd == c) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) cyc++;

  // Reference: a queue of accepted writes, one retired per cycle into an output slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
    end else begin
      m_room = (mq.size() < DEPTH);
      m_have = 1'b0;
      m_acc  = '0;
      if (bus.ld_valid && m_room) begin
        m_have = 1'b1;
        m_acc  = '{rd: bus.ld_rd, data: bus.ld_data};
      end else if (bus.alu_valid && m_room) begin
        m_have = 1'b1;
        m_acc  = '{rd: bus.alu_rd, data: bus.alu_data};
      end
      if (mq.size() > 0) begin
        m_pop  = mq.pop_front();
        m_we   = 1'b1;
        m_rd   = m_pop.rd;
        m_data = m_pop.data;
        m_log.push_back('{cyc: 0, rd: m_pop.rd, data: m_pop.data});
      end else begin
        m_we = 1'b0;
      end
      if (m_have && m_acc.rd != 5'd0) mq.push_back(m_acc);
    end
  end

  // Every-cycle comparison of all outputs against the reference, plus a write log.
  always @(negedge clk) begin
    logic exp_lr;
    exp_lr = rst_n && (mq.size() < DEPTH);
    chk("ld_ready",  64'(bus.ld_ready),  64'(exp_lr));
    chk("alu_ready", 64'(bus.alu_ready), 64'(exp_lr && !bus.ld_valid));
    chk("RegWrite",  64'(bus.RegWrite),  64'(m_we));
    chk("rd",        64'(bus.rd),        64'(m_rd));
    chk("data_in",   64'(bus.data_in),   64'(m_data));
    chk("pend_rs1",  64'(bus.pend_rs1),  64'(m_pend(bus.chk_rs1)));
    chk("pend_rs2",  64'(bus.pend_rs2),  64'(m_pend(bus.chk_rs2)));
    if (bus.RegWrite) dut_log.push_back('{cyc: cyc, rd: bus.rd, data: bus.data_in});
  end

  logic [31:0] exp_d[1:12];
  logic        dropped;
  int          k;

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.chk_rs1   = '0;   bus.chk_rs2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_RegWrite",  64'(bus.RegWrite),  64'(0));
    chk("rst_rd",        64'(bus.rd),        64'(0));
    chk("rst_data_in",   64'(bus.data_in),   64'(0));
    chk("rst_ld_ready",  64'(bus.ld_ready),  64'(0));
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ld_ready", 64'(bus.ld_ready), 64'(1));

    // Single ALU write: appears two edges after being driven, for one cycle
    step();
    dut_log.delete(); m_log.delete();
    k = cyc;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    step();
    idle();
    repeat (4) step();
    chk("single_count", 64'(dut_log.size()), 64'(1));
    if (dut_log.size() == 1) begin
      chk("single_rd",   64'(dut_log[0].rd),   64'(5));
      chk("single_data", 64'(dut_log[0].data), 64'(32'hDEADBEEF));
      chk("single_cyc",  64'(dut_log[0].cyc),  64'(k + 2));
    end
    chk("model_single_count", 64'(m_log.size()), 64'(1));
    if (m_log.size() == 1) chk("model_single_rd", 64'(m_log[0].rd), 64'(5));

    // Simultaneous offer: load first, ALU held off that cycle
    dut_log.delete(); m_log.delete();
    k = cyc;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd3; bus.ld_data  = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h22;
    @(negedge clk);
    chk("simul_alu_ready", 64'(bus.alu_ready), 64'(0));
    chk("simul_ld_ready",  64'(bus.ld_ready),  64'(1));
    step();
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("simul_alu_ready2", 64'(bus.alu_ready), 64'(1));
    step();
    idle();
    repeat (4) step();
    chk("simul_count", 64'(dut_log.size()), 64'(2));
    if (dut_log.size() == 2) begin
      chk("simul_rd0",   64'(dut_log[0].rd),   64'(3));
      chk("simul_data0", 64'(dut_log[0].data), 64'(32'h11));
      chk("simul_cyc0",  64'(dut_log[0].cyc),  64'(k + 2));
      chk("simul_rd1",   64'(dut_log[1].rd),   64'(4));
      chk("simul_data1", 64'(dut_log[1].data), 64'(32'h22));
      chk("simul_cyc1",  64'(dut_log[1].cyc),  64'(k + 3));
    end
    if (m_log.size() == 2) chk("model_simul_order", 64'({m_log[0].rd, m_log[1].rd}), 64'({5'd3, 5'd4}));
    else chk("model_simul_count", 64'(m_log.size()), 64'(2));

    // x0 drop
    dut_log.delete();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
    bus.chk_rs1 = 5'd0;
    @(negedge clk);
    chk("x0_alu_ready", 64'(bus.alu_ready), 64'(1));
    step();
    idle();
    repeat (3) step();
    chk("x0_no_write", 64'(dut_log.size()), 64'(0));
    chk("x0_pend",     64'(bus.pend_rs1),   64'(0));

    // Twelve back-to-back writes: ready stays high, order kept, pointers wrap
    dut_log.delete();
    dropped = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      exp_d[i] = $urandom;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(i); bus.alu_data = exp_d[i];
      @(negedge clk);
      if (!bus.alu_ready) dropped = 1'b1;
      step();
    end
    idle();
    repeat (4) step();
    chk("wrap_no_drop", 64'(dropped), 64'(0));
    chk("wrap_count",   64'(dut_log.size()), 64'(12));
    if (dut_log.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("wrap_rd",   64'(dut_log[i].rd),   64'(i + 1));
        chk("wrap_data", 64'(dut_log[i].data), 64'(exp_d[i+1]));
        chk("wrap_cyc",  64'(dut_log[i].cyc - dut_log[0].cyc), 64'(i));
      end
    end

    // Hazard window: offered-only is not pending; pending through the write cycle
    for (int i = 0; i < 5; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(6 + i); bus.alu_data = 32'(i);
      bus.chk_rs1 = 5'(6 + i);
      @(negedge clk);
      chk("haz_unaccepted", 64'(bus.pend_rs1), 64'(0));
      step();
    end
    idle();
    @(negedge clk);
    chk("haz_queued", 64'(bus.pend_rs1), 64'(1));
    step();
    @(negedge clk);
    chk("haz_writing",    64'(bus.pend_rs1), 64'(1));
    chk("haz_writing_rd", 64'(bus.rd),       64'(10));
    step();
    @(negedge clk);
    chk("haz_done", 64'(bus.pend_rs1), 64'(0));
    repeat (2) step();

    // Reset mid-stream
    bus.chk_rs1 = 5'd21; bus.chk_rs2 = 5'd22;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + i); bus.alu_data = 32'(100 + i);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_RegWrite", 64'(bus.RegWrite),  64'(0));
    chk("mid_rst_pend1",    64'(bus.pend_rs1),  64'(0));
    chk("mid_rst_pend2",    64'(bus.pend_rs2),  64'(0));
    chk("mid_rst_ready",    64'(bus.alu_ready), 64'(0));
    dut_log.delete();
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("mid_rst_no_write", 64'(dut_log.size()), 64'(0));

    // Randomized traffic with collisions and x0 targets
    for (int i = 0; i < 300; i++) begin
      bus.ld_valid  = ($urandom_range(0, 2) == 0);
      bus.alu_valid = $urandom_range(0, 1) == 1;
      bus.ld_rd     = 5'($urandom_range(0, 7));
      bus.alu_rd    = 5'($urandom_range(0, 7));
      bus.ld_data   = $urandom;
      bus.alu_data  = $urandom;
      bus.chk_rs1   = 5'($urandom_range(0, 7));
      bus.chk_rs2   = 5'($urandom_range(0, 7));
      if (i == 150) begin
        #3;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    idle();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
